// File: rtl/parking_billing_ctrl.sv
// parking_billing_ctrl
// Write-side controller for a 3-car entry-time/cost memory.
// On a car arrival it records the arrival time. On a departure it reads the
// stored entry time, computes the elapsed time and the cost, writes the cost
// back, and then offers a bill over a valid/ready handshake.
//
// Ports
//   clk, reset_n        : rising-edge clock, asynchronous active-low reset
//   time_now            : free-running time base (wraps modulo 2^TIME_W)
//   entry_req/exit_req  : one-hot arrival/departure pulses (bit0=car1)
//   car_sel             : one-hot memory select, 000 when idle
//   write_entry         : entry-time write strobe, data on entry_time_wr
//   write_cost          : cost write strobe, data on cost_wr
//   entry_time_rd       : combinational memory read of the selected car
//   occupancy           : bit set = car parked
//   busy                : controller not idle; requests are ignored
//   bill_valid/ready    : bill handshake, payload bill_car/bill_cost
//   error               : pulses in the cycle a request is rejected
module parking_billing_ctrl #(
  parameter int unsigned TIME_W   = 10,
  parameter int unsigned RATE     = 2,
  parameter int unsigned COST_MAX = 1023
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic [TIME_W-1:0] time_now,
  input  logic [2:0]        entry_req,
  input  logic [2:0]        exit_req,
  output logic [2:0]        car_sel,
  output logic              write_entry,
  output logic              write_cost,
  output logic [TIME_W-1:0] entry_time_wr,
  output logic [TIME_W-1:0] cost_wr,
  input  logic [TIME_W-1:0] entry_time_rd,
  output logic [2:0]        occupancy,
  output logic              busy,
  output logic              bill_valid,
  input  logic              bill_ready,
  output logic [2:0]        bill_car,
  output logic [TIME_W-1:0] bill_cost,
  output logic              error
);

  localparam int unsigned PROD_W = TIME_W + $clog2(RATE + 1);

  typedef enum logic [2:0] {
    IDLE, ENTRY_WR, EXIT_RD, EXIT_CALC, COST_WR, BILL
  } state_t;

  state_t            state, state_nxt;
  logic [2:0]        car_q;
  logic [TIME_W-1:0] time_q;     // entry time or exit time of the latched car
  logic [TIME_W-1:0] elapsed_q;
  logic [TIME_W-1:0] cost_q;
  logic [2:0]        occ_q;

  logic              entry_ok, exit_ok;
  logic              accept_entry, accept_exit;
  logic [PROD_W-1:0] product;
  logic [TIME_W-1:0] cost_sat;

  assign entry_ok = $onehot(entry_req) && ((entry_req & occ_q) == 3'b000);
  assign exit_ok  = $onehot(exit_req)  && ((exit_req & occ_q) == exit_req);

  // Entry has priority; a simultaneous exit is dropped and flagged.
  always_comb begin
    accept_entry = 1'b0;
    accept_exit  = 1'b0;
    error        = 1'b0;
    if (state == IDLE) begin
      if (entry_req != 3'b000) begin
        accept_entry = entry_ok;
        error        = !entry_ok || (exit_req != 3'b000);
      end else if (exit_req != 3'b000) begin
        accept_exit = exit_ok;
        error       = !exit_ok;
      end
    end
  end

  assign product  = PROD_W'(elapsed_q) * PROD_W'(RATE);
  assign cost_sat = (product > PROD_W'(COST_MAX)) ? TIME_W'(COST_MAX)
                                                  : product[TIME_W-1:0];

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:      if (accept_entry) state_nxt = ENTRY_WR;
                 else if (accept_exit) state_nxt = EXIT_RD;
      ENTRY_WR:  state_nxt = IDLE;
      EXIT_RD:   state_nxt = EXIT_CALC;
      EXIT_CALC: state_nxt = COST_WR;
      COST_WR:   state_nxt = BILL;
      BILL:      if (bill_ready) state_nxt = IDLE;
      default:   state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state     <= IDLE;
      car_q     <= '0;
      time_q    <= '0;
      elapsed_q <= '0;
      cost_q    <= '0;
      occ_q     <= '0;
    end else begin
      state <= state_nxt;
      case (state)
        IDLE: begin
          if (accept_entry) begin
            car_q  <= entry_req;
            time_q <= time_now;
          end else if (accept_exit) begin
            car_q  <= exit_req;
            time_q <= time_now;
          end
        end
        ENTRY_WR:  occ_q     <= occ_q | car_q;
        // Unsigned subtraction wraps, giving the forward distance.
        EXIT_RD:   elapsed_q <= time_q - entry_time_rd;
        EXIT_CALC: cost_q    <= cost_sat;
        BILL:      if (bill_ready) occ_q <= occ_q & ~car_q;
        default: ;
      endcase
    end
  end

  always_comb begin
    car_sel       = '0;
    write_entry   = 1'b0;
    write_cost    = 1'b0;
    entry_time_wr = '0;
    cost_wr       = '0;
    bill_valid    = 1'b0;
    bill_car      = '0;
    bill_cost     = '0;
    case (state)
      ENTRY_WR: begin
        car_sel       = car_q;
        write_entry   = 1'b1;
        entry_time_wr = time_q;
      end
      EXIT_RD, EXIT_CALC: car_sel = car_q;
      COST_WR: begin
        car_sel    = car_q;
        write_cost = 1'b1;
        cost_wr    = cost_q;
      end
      BILL: begin
        car_sel    = car_q;
        bill_valid = 1'b1;
        bill_car   = car_q;
        bill_cost  = cost_q;
      end
      default: ;
    endcase
  end

  assign occupancy = occ_q;
  assign busy      = (state != IDLE);

endmodule

// File: tb/tb_parking_billing_ctrl.sv
module tb_parking_billing_ctrl;

  logic       clk = 1'b0;
  logic       reset_n;
  logic [9:0] time_now;
  logic [2:0] entry_req, exit_req;
  logic [2:0] car_sel;
  logic       write_entry, write_cost;
  logic [9:0] entry_time_wr, cost_wr, entry_time_rd;
  logic [2:0] occupancy;
  logic       busy, bill_valid, bill_ready;
  logic [2:0] bill_car;
  logic [9:0] bill_cost;
  logic       error;

  int unsigned n_checks = 0;
  int unsigned n_errors = 0;

  always #5 clk = ~clk;

  parking_billing_ctrl #(.TIME_W(10), .RATE(2), .COST_MAX(1023)) dut (
    .clk(clk), .reset_n(reset_n), .time_now(time_now),
    .entry_req(entry_req), .exit_req(exit_req), .car_sel(car_sel),
    .write_entry(write_entry), .write_cost(write_cost),
    .entry_time_wr(entry_time_wr), .cost_wr(cost_wr),
    .entry_time_rd(entry_time_rd), .occupancy(occupancy), .busy(busy),
    .bill_valid(bill_valid), .bill_ready(bill_ready), .bill_car(bill_car),
    .bill_cost(bill_cost), .error(error)
  );

  // Simple 3-entry memory standing in for the real entry-time store.
  logic [9:0] mem [3];
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < 3; i++) mem[i] <= '0;
    end else if (write_entry) begin
      for (int i = 0; i < 3; i++) if (car_sel[i]) mem[i] <= entry_time_wr;
    end
  end
  always_comb begin
    entry_time_rd = '0;
    for (int i = 0; i < 3; i++) if (car_sel[i]) entry_time_rd = mem[i];
  end

  typedef struct {
    logic [2:0] ent, ext; logic [9:0] tn; logic rdy;
    logic [2:0] sel; logic we, wc; logic [9:0] etw, cw;
    logic [2:0] occ; logic bsy, bv; logic [2:0] bc; logic [9:0] bcost; logic err;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(
    logic [2:0] ent, logic [2:0] ext, logic [9:0] tn, logic rdy,
    logic [2:0] sel, logic we, logic wc, logic [9:0] etw, logic [9:0] cw,
    logic [2:0] occ, logic bsy, logic bv, logic [2:0] bc, logic [9:0] bcost,
    logic err);
    vec_t v;
    v.ent = ent; v.ext = ext; v.tn = tn; v.rdy = rdy;
    v.sel = sel; v.we = we; v.wc = wc; v.etw = etw; v.cw = cw;
    v.occ = occ; v.bsy = bsy; v.bv = bv; v.bc = bc; v.bcost = bcost; v.err = err;
    return v;
  endfunction

  task automatic chk(input string name, input int unsigned act, input int unsigned exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic chk_all(input string tag, input vec_t v);
    chk({tag, "_sel"},   car_sel,       v.sel);
    chk({tag, "_we"},    write_entry,   v.we);
    chk({tag, "_wc"},    write_cost,    v.wc);
    chk({tag, "_etw"},   entry_time_wr, v.etw);
    chk({tag, "_cw"},    cost_wr,       v.cw);
    chk({tag, "_occ"},   occupancy,     v.occ);
    chk({tag, "_busy"},  busy,          v.bsy);
    chk({tag, "_bv"},    bill_valid,    v.bv);
    chk({tag, "_bc"},    bill_car,      v.bc);
    chk({tag, "_bcost"}, bill_cost,     v.bcost);
    chk({tag, "_err"},   error,         v.err);
  endtask

  task automatic drive(input logic [2:0] ent, input logic [2:0] ext,
                       input logic [9:0] tn, input logic rdy);
    entry_req = ent; exit_req = ext; time_now = tn; bill_ready = rdy;
  endtask

  initial begin
    //         ent     ext     tn   rdy  sel     we wc etw   cw    occ     bsy bv bc      bcost err
    // car2 entry at 100, exit at 130 -> cost 60; ready held low 3 cycles
    vecs.push_back(mk(3'b010, 3'b000, 100, 0, 3'b000, 0, 0, 0,    0,    3'b000, 0, 0, 3'b000, 0,    0));
    vecs.push_back(mk(3'b000, 3'b000, 0,   0, 3'b010, 1, 0, 100,  0,    3'b000, 1, 0, 3'b000, 0,    0));
    vecs.push_back(mk(3'b000, 3'b010, 130, 0, 3'b000, 0, 0, 0,    0,    3'b010, 0, 0, 3'b000, 0,    0));
    vecs.push_back(mk(3'b001, 3'b000, 0,   0, 3'b010, 0, 0, 0,    0,    3'b010, 1, 0, 3'b000, 0,    0));
    vecs.push_back(mk(3'b000, 3'b000, 0,   0, 3'b010, 0, 0, 0,    0,    3'b010, 1, 0, 3'b000, 0,    0));
    vecs.push_back(mk(3'b000, 3'b000, 0,   0, 3'b010, 0, 1, 0,    60,   3'b010, 1, 0, 3'b000, 0,    0));
    vecs.push_back(mk(3'b000, 3'b000, 0,   0, 3'b010, 0, 0, 0,    0,    3'b010, 1, 1, 3'b010, 60,   0));
    vecs.push_back(mk(3'b000, 3'b000, 0,   0, 3'b010, 0, 0, 0,    0,    3'b010, 1, 1, 3'b010, 60,   0));
    vecs.push_back(mk(3'b000, 3'b100, 0,   0, 3'b010, 0, 0, 0,    0,    3'b010, 1, 1, 3'b010, 60,   0));
    vecs.push_back(mk(3'b000, 3'b000, 0,   1, 3'b010, 0, 0, 0,    0,    3'b010, 1, 1, 3'b010, 60,   0));
    vecs.push_back(mk(3'b000, 3'b000, 0,   0, 3'b000, 0, 0, 0,    0,    3'b000, 0, 0, 3'b000, 0,    0));
    // wrap-around: car1 entry 1020, exit 5 -> elapsed 9, cost 18
    vecs.push_back(mk(3'b001, 3'b000, 1020,0, 3'b000, 0, 0, 0,    0,    3'b000, 0, 0, 3'b000, 0,    0));
    vecs.push_back(mk(3'b000, 3'b000, 0,   0, 3'b001, 1, 0, 1020, 0,    3'b000, 1, 0, 3'b000, 0,    0));
    vecs.push_back(mk(3'b000, 3'b001, 5,   0, 3'b000, 0, 0, 0,    0,    3'b001, 0, 0, 3'b000, 0,    0));
    vecs.push_back(mk(3'b000, 3'b000, 0,   0, 3'b001, 0, 0, 0,    0,    3'b001, 1, 0, 3'b000, 0,    0));
    vecs.push_back(mk(3'b000, 3'b000, 0,   0, 3'b001, 0, 0, 0,    0,    3'b001, 1, 0, 3'b000, 0,    0));
    vecs.push_back(mk(3'b000, 3'b000, 0,   0, 3'b001, 0, 1, 0,    18,   3'b001, 1, 0, 3'b000, 0,    0));
    vecs.push_back(mk(3'b000, 3'b000, 0,   1, 3'b001, 0, 0, 0,    0,    3'b001, 1, 1, 3'b001, 18,   0));
    vecs.push_back(mk(3'b000, 3'b000, 0,   0, 3'b000, 0, 0, 0,    0,    3'b000, 0, 0, 3'b000, 0,    0));
    // saturation: car3 entry 0, exit 600 -> product 1200 -> 1023
    vecs.push_back(mk(3'b100, 3'b000, 0,   0, 3'b000, 0, 0, 0,    0,    3'b000, 0, 0, 3'b000, 0,    0));
    vecs.push_back(mk(3'b000, 3'b000, 0,   0, 3'b100, 1, 0, 0,    0,    3'b000, 1, 0, 3'b000, 0,    0));
    vecs.push_back(mk(3'b000, 3'b100, 600, 0, 3'b000, 0, 0, 0,    0,    3'b100, 0, 0, 3'b000, 0,    0));
    vecs.push_back(mk(3'b000, 3'b000, 0,   0, 3'b100, 0, 0, 0,    0,    3'b100, 1, 0, 3'b000, 0,    0));
    vecs.push_back(mk(3'b000, 3'b000, 0,   0, 3'b100, 0, 0, 0,    0,    3'b100, 1, 0, 3'b000, 0,    0));
    vecs.push_back(mk(3'b000, 3'b000, 0,   0, 3'b100, 0, 1, 0,    1023, 3'b100, 1, 0, 3'b000, 0,    0));
    vecs.push_back(mk(3'b000, 3'b000, 0,   1, 3'b100, 0, 0, 0,    0,    3'b100, 1, 1, 3'b100, 1023, 0));
    vecs.push_back(mk(3'b000, 3'b000, 0,   0, 3'b000, 0, 0, 0,    0,    3'b000, 0, 0, 3'b000, 0,    0));
    // rejected: exit of absent car1, then entry with two bits set
    vecs.push_back(mk(3'b000, 3'b001, 7,   0, 3'b000, 0, 0, 0,    0,    3'b000, 0, 0, 3'b000, 0,    1));
    vecs.push_back(mk(3'b000, 3'b000, 0,   0, 3'b000, 0, 0, 0,    0,    3'b000, 0, 0, 3'b000, 0,    0));
    vecs.push_back(mk(3'b011, 3'b000, 8,   0, 3'b000, 0, 0, 0,    0,    3'b000, 0, 0, 3'b000, 0,    1));
    vecs.push_back(mk(3'b000, 3'b000, 0,   0, 3'b000, 0, 0, 0,    0,    3'b000, 0, 0, 3'b000, 0,    0));
    // car3 parked at 50, then car1 entry + car3 exit together at 70
    vecs.push_back(mk(3'b100, 3'b000, 50,  0, 3'b000, 0, 0, 0,    0,    3'b000, 0, 0, 3'b000, 0,    0));
    vecs.push_back(mk(3'b000, 3'b000, 0,   0, 3'b100, 1, 0, 50,   0,    3'b000, 1, 0, 3'b000, 0,    0));
    vecs.push_back(mk(3'b001, 3'b100, 70,  0, 3'b000, 0, 0, 0,    0,    3'b100, 0, 0, 3'b000, 0,    1));
    vecs.push_back(mk(3'b000, 3'b000, 0,   0, 3'b001, 1, 0, 70,   0,    3'b100, 1, 0, 3'b000, 0,    0));
    // zero elapsed: car1 exits at 70 -> cost 0, bill still issued
    vecs.push_back(mk(3'b000, 3'b001, 70,  0, 3'b000, 0, 0, 0,    0,    3'b101, 0, 0, 3'b000, 0,    0));
    vecs.push_back(mk(3'b000, 3'b000, 0,   0, 3'b001, 0, 0, 0,    0,    3'b101, 1, 0, 3'b000, 0,    0));
    vecs.push_back(mk(3'b000, 3'b000, 0,   0, 3'b001, 0, 0, 0,    0,    3'b101, 1, 0, 3'b000, 0,    0));
    vecs.push_back(mk(3'b000, 3'b000, 0,   0, 3'b001, 0, 1, 0,    0,    3'b101, 1, 0, 3'b000, 0,    0));
    vecs.push_back(mk(3'b000, 3'b000, 0,   1, 3'b001, 0, 0, 0,    0,    3'b101, 1, 1, 3'b001, 0,    0));
    // entry for already-parked car3 is rejected
    vecs.push_back(mk(3'b100, 3'b000, 90,  0, 3'b000, 0, 0, 0,    0,    3'b100, 0, 0, 3'b000, 0,    1));
    vecs.push_back(mk(3'b000, 3'b000, 0,   0, 3'b000, 0, 0, 0,    0,    3'b100, 0, 0, 3'b000, 0,    0));

    reset_n = 1'b0;
    drive(3'b000, 3'b000, 0, 1'b0);
    repeat (2) @(posedge clk);
    #1;
    chk("rst_sel", car_sel, 0);
    chk("rst_occ", occupancy, 0);
    chk("rst_busy", busy, 0);
    chk("rst_bv", bill_valid, 0);
    chk("rst_err", error, 0);
    reset_n = 1'b1;

    for (int i = 0; i < vecs.size(); i++) begin
      @(posedge clk); #1;
      drive(vecs[i].ent, vecs[i].ext, vecs[i].tn, vecs[i].rdy);
      @(negedge clk);
      chk_all($sformatf("r%0d", i), vecs[i]);
    end

    // Reset asserted while a bill is pending: car3 (entered at 50) exits at 80.
    @(posedge clk); #1;
    drive(3'b000, 3'b100, 80, 1'b0);
    @(posedge clk); #1;
    drive(3'b000, 3'b000, 0, 1'b0);
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("pre_rst_bv", bill_valid, 1);
    chk("pre_rst_bcost", bill_cost, 60);
    #2 reset_n = 1'b0;
    #1;
    chk("arst_bv", bill_valid, 0);
    chk("arst_occ", occupancy, 0);
    chk("arst_sel", car_sel, 0);
    chk("arst_we", write_entry, 0);
    chk("arst_wc", write_cost, 0);
    chk("arst_busy", busy, 0);
    @(posedge clk); #1;
    reset_n = 1'b1;
    @(posedge clk); #1;
    drive(3'b010, 3'b000, 200, 1'b0);
    @(negedge clk);
    chk("post_err", error, 0);
    @(posedge clk); #1;
    drive(3'b000, 3'b000, 0, 1'b0);
    @(negedge clk);
    chk("post_we", write_entry, 1);
    chk("post_etw", entry_time_wr, 200);
    chk("post_sel", car_sel, 3'b010);
    @(posedge clk); #1;
    @(negedge clk);
    chk("post_occ", occupancy, 3'b010);
    chk("post_busy", busy, 0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/parking_billing_ctrl.md
Name: parking_billing_ctrl

Overview:
Control FSM that drives the per-car entry-time/cost memory from the write side. It sits between the gate sensors/time base and the 3-car memory. On car entry it records the arrival time. On car exit it reads the stored entry time, computes elapsed time and cost, writes the cost back, then presents a bill over a valid/ready handshake.

Parameters:
TIME_W, 10, width of time, entry-time and cost values
RATE, 2, cost units charged per time unit
COST_MAX, 1023, saturation ceiling for cost (must fit in TIME_W bits)

Ports:
clk  in  1  system clock, rising edge
reset_n  in  1  asynchronous, active-low reset
time_now  in  TIME_W  free-running time count; wraps modulo 2^TIME_W
entry_req  in  3  one-hot car arrival pulse (001=car1, 010=car2, 100=car3)
exit_req  in  3  one-hot car departure pulse, same encoding
car_sel  out  3  one-hot memory select; 000 in IDLE
write_entry  out  1  memory entry-time write strobe
write_cost  out  1  memory cost write strobe
entry_time_wr  out  TIME_W  entry time to write
cost_wr  out  TIME_W  cost to write
entry_time_rd  in  TIME_W  memory combinational read of the selected car's entry time
occupancy  out  3  bit set = car parked
busy  out  1  high whenever state != IDLE
bill_valid  out  1  bill available
bill_ready  in  1  bill consumer accepts
bill_car  out  3  one-hot car for the bill
bill_cost  out  TIME_W  billed cost
error  out  1  one-cycle pulse on a rejected request

Behaviour:
- Reset (async assert, sync deassert by the flop): state=IDLE. All outputs 0; occupancy=000. Internal latches cleared. Reset mid-operation aborts with no further strobes; the memory is cleared by its own reset.
- States: IDLE, ENTRY_WR, EXIT_RD, EXIT_CALC, COST_WR, BILL.
- Requests are sampled only in IDLE. Requests in other states are ignored silently; busy tells the source to hold off.
- IDLE, entry_req nonzero:
  - Valid = exactly one bit set and that car's occupancy bit is 0.
  - If valid: latch car and time_now, go to ENTRY_WR.
  - If invalid: error=1 for one cycle, stay in IDLE.
- ENTRY_WR (1 cycle): car_sel=latched car, write_entry=1, entry_time_wr=latched time. Set occupancy bit at the end of the cycle, then go to IDLE.
- IDLE, exit_req nonzero and entry_req zero:
  - Valid = exactly one bit set and that car's occupancy bit is 1.
  - If valid: latch car and time_now as exit time, go to EXIT_RD.
  - If invalid: error pulse, stay in IDLE.
- Simultaneous entry_req and exit_req in IDLE: entry is handled as above, exit is dropped, and error pulses in the same cycle.
- EXIT_RD (1 cycle): car_sel=car. Register elapsed = (exit_time - entry_time_rd) mod 2^TIME_W, so wrap-around yields the forward distance.
- EXIT_CALC (1 cycle): car_sel=car. Compute product = elapsed*RATE at full width (TIME_W + clog2(RATE+1) bits). Register cost = min(product, COST_MAX).
- COST_WR (1 cycle): car_sel=car, write_cost=1, cost_wr=cost.
- BILL: car_sel=car, bill_valid=1, bill_car=car, bill_cost=cost.
  - bill_car and bill_cost are held stable until bill_valid && bill_ready.
  - On handshake: clear the occupancy bit and go to IDLE next cycle. bill_valid is 0 in IDLE.
- Latency: write_entry is asserted in the cycle after entry acceptance. write_cost is asserted 3 cycles after exit acceptance. bill_valid is asserted 4 cycles after exit acceptance. Minimum exit-to-IDLE is 5 cycles.
- Strobes are high for exactly one cycle per accepted request, and never both high together.
- Zero elapsed (exit in the same time unit) gives cost 0, and the bill is still issued.

Test Plan:
- Entry car2 at time_now=100 -> next cycle car_sel=010, write_entry=1, entry_time_wr=100; occupancy=010 after; error=0.
- Exit car2 at time_now=130, entry_time_rd=100, RATE=2 -> write_cost=1 with cost_wr=60 at +3 cycles; bill_valid at +4 with bill_car=010, bill_cost=60. Hold bill_ready low 3 cycles: outputs stable. Then ready=1 -> occupancy=000, busy=0 next cycle.
- Wrap-around: entry at 1020, exit at 5 -> elapsed 9, cost_wr=18.
- Saturation: entry at 0, exit at 600 -> product 1200, cost_wr=1023.
- Errors:
  - exit_req=001 with car1 absent -> one error pulse, no strobes, state IDLE.
  - entry_req=011 -> error pulse, no write.
  - entry car1 plus exit car3 (car3 parked) in the same cycle -> car1 entry written, error pulse, car3 stays parked.
  - Requests while busy -> ignored, no error.
- Assert reset_n=0 during BILL -> asynchronously bill_valid=0, occupancy=000, car_sel=000, no strobes. After release, a new entry is accepted normally.
